seq_divider: RTL

// Iterative unsigned restoring divider. It is the inverse arithmetic path to the

---
 rtl/seq_divider_pkg.sv | 15 +
 rtl/seq_divider_div_step.sv | 24 ++
 rtl/seq_divider.sv | 102 ++++++++++
 3 files changed

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the iterative divider: FSM encodings and counter sizing.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter must hold the value WIDTH itself, hence w+1.
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, subtract if it fits.
module div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] rem_shift;
  logic           fits;

  assign rem_shift = {rem[WIDTH-1:0], quo[WIDTH-1]};

  // Compare on the unshifted-out view too so a non-canonical rem can never wrap.
  always_comb begin
    fits     = ({rem, quo[WIDTH-1]} >= {2'b00, b});
    rem_next = fits ? (rem_shift - {1'b0, b}) : rem_shift;
    quo_next = {quo[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock, valid/ready on both sides.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_by_zero
);

  localparam int CNT_W = cnt_w(WIDTH);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH:0]   rem_reg;
  logic [WIDTH-1:0] b_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH:0]   rem_next;
  logic             last_step;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_reg),
    .quo      (quo_reg),
    .b        (b_reg),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  assign last_step = (cnt_reg == CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (in_valid) state_next = (b == '0) ? ST_DONE : ST_CALC;
      ST_CALC: if (last_step) state_next = ST_DONE;
      ST_DONE: if (out_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_reg == ST_IDLE);
    out_valid = (state_reg == ST_DONE);
  end

  // Result registers are loaded only on entry to DONE, so they hold the last
  // result through IDLE and the next calculation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_reg     <= '0;
      rem_reg     <= '0;
      b_reg       <= '0;
      cnt_reg     <= '0;
      q           <= '0;
      r           <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            quo_reg <= a;
            rem_reg <= '0;
            b_reg   <= b;
            cnt_reg <= CNT_W'(WIDTH);
            if (b == '0) begin
              q           <= '1;
              r           <= a;
              div_by_zero <= 1'b1;
            end
          end
        end
        ST_CALC: begin
          quo_reg <= quo_next;
          rem_reg <= rem_next;
          cnt_reg <= cnt_reg - CNT_W'(1);
          if (last_step) begin
            q           <= quo_next;
            r           <= rem_next[WIDTH-1:0];
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
